amo_rmw_seq: RTL and testbench

//  Sequences AMO read-modify-write (RMW) operations in the LSU.
//  - Sits downstream of the LR/SC reservation stage and consumes its post-squash LSURWM and LSUAtomicM.
//  - For each AMO: read memory, compute the AMO result, write it back, return the old value, stall M meanwhile.
//  - Non-AMO ops (incl. LR/SC) pass through untouched; the block does nothing for them.

---
 rtl/amo_rmw_seq.sv | 168 ++++++++++++++++
 tb/tb_amo_rmw_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_rmw_seq.sv
// AMO read-modify-write sequencer: for each AMO, reads memory, applies the AMO ALU,
// writes the result back, and returns the old value, while holding the M stage.
module amo_rmw_seq #(
    parameter int XLEN    = 64,
    parameter int PA_BITS = 56
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           LSURWM,
    input  logic [1:0]           LSUAtomicM,
    input  logic [4:0]           AtomicOpM,
    input  logic                 AmoWordM,
    input  logic                 FlushM,
    input  logic [PA_BITS-1:0]   PAdrM,
    input  logic [XLEN-1:0]      WriteDataM,
    output logic                 BusReq,
    output logic                 BusWrite,
    output logic [PA_BITS-1:0]   BusAdr,
    output logic [XLEN/8-1:0]    BusByteEn,
    output logic [XLEN-1:0]      BusWData,
    input  logic                 BusAck,
    input  logic [XLEN-1:0]      BusRData,
    output logic                 AmoStallM,
    output logic                 AmoDoneM,
    output logic [XLEN-1:0]      ReadDataM
);

    localparam int OFFB = $clog2(XLEN/8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } stateT;

    stateT state, nextState;

    logic                start;
    logic [PA_BITS-1:0]  adrQ;
    logic [4:0]          opQ;
    logic                wordQ;
    logic [XLEN-1:0]     wdataQ;
    logic [XLEN-1:0]     resultQ;
    logic [XLEN-1:0]     oldQ;
    logic [XLEN-1:0]     readDataQ;

    logic [XLEN-1:0]     oldVal;
    logic [XLEN-1:0]     opB;
    logic [XLEN-1:0]     aluRes;
    logic [XLEN-1:0]     wrData;
    logic [XLEN/8-1:0]   byteEn;

    assign start = (state == IDLE) & LSUAtomicM[1] & (LSURWM == 2'b11) & ~FlushM & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FlushM only gates the start; an issued RMW always runs to DONE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start)  nextState = READ;
            READ:    if (BusAck) nextState = WRITE;
            WRITE:   if (BusAck) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        BusReq    = 1'b0;
        BusWrite  = 1'b0;
        AmoDoneM  = 1'b0;
        AmoStallM = start;
        case (state)
            READ: begin
                BusReq    = 1'b1;
                AmoStallM = 1'b1;
            end
            WRITE: begin
                BusReq    = 1'b1;
                BusWrite  = 1'b1;
                AmoStallM = 1'b1;
            end
            DONE: begin
                AmoDoneM  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adrQ      <= '0;
            opQ       <= '0;
            wordQ     <= 1'b0;
            wdataQ    <= '0;
            resultQ   <= '0;
            oldQ      <= '0;
            readDataQ <= '0;
        end else begin
            if (start) begin
                adrQ   <= PAdrM;
                opQ    <= AtomicOpM;
                wordQ  <= AmoWordM;
                wdataQ <= WriteDataM;
            end
            if ((state == READ) && BusAck) begin
                oldQ    <= oldVal;
                resultQ <= wrData;
            end
            // ReadDataM only changes when an AMO completes, so it holds across the next RMW.
            if ((state == WRITE) && BusAck) begin
                readDataQ <= oldQ;
            end
        end
    end

    // Word ops sign-extend both operands to XLEN; this keeps signed and unsigned
    // ordering of the 32-bit values intact, so one full-width ALU serves both widths.
    generate
        if (XLEN == 64) begin : gXlen64
            logic [31:0] lane;
            logic        unusedAdrBits;

            assign lane          = adrQ[2] ? BusRData[63:32] : BusRData[31:0];
            assign oldVal        = wordQ ? {{32{lane[31]}}, lane} : BusRData;
            assign opB           = wordQ ? {{32{wdataQ[31]}}, wdataQ[31:0]} : wdataQ;
            assign wrData        = wordQ ? {2{aluRes[31:0]}} : aluRes;
            assign byteEn        = wordQ ? (adrQ[2] ? 8'hF0 : 8'h0F) : 8'hFF;
            assign unusedAdrBits = ^adrQ[1:0];
        end else begin : gXlen32
            logic unusedBits;

            assign oldVal     = BusRData;
            assign opB        = wdataQ;
            assign wrData     = aluRes;
            assign byteEn     = '1;
            assign unusedBits = ^{adrQ[1:0], wordQ};
        end
    endgenerate

    always_comb begin
        case (opQ)
            5'b00000: aluRes = oldVal + opB;
            5'b00100: aluRes = oldVal ^ opB;
            5'b01100: aluRes = oldVal & opB;
            5'b01000: aluRes = oldVal | opB;
            5'b10000: aluRes = ($signed(oldVal) < $signed(opB)) ? oldVal : opB;
            5'b10100: aluRes = ($signed(oldVal) > $signed(opB)) ? oldVal : opB;
            5'b11000: aluRes = (oldVal < opB) ? oldVal : opB;
            5'b11100: aluRes = (oldVal > opB) ? oldVal : opB;
            default:  aluRes = opB;
        endcase
    end

    assign BusAdr    = {adrQ[PA_BITS-1:OFFB], {OFFB{1'b0}}};
    assign BusByteEn = byteEn;
    assign BusWData  = resultQ;
    assign ReadDataM = readDataQ;

endmodule

// File: tb/tb_amo_rmw_seq.sv
// Directed self-checking bench for amo_rmw_seq: drives AMOs and acts as the bus
// responder inline, comparing against hand-computed results.
module tb_amo_rmw_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  LSURWM;
    logic [1:0]  LSUAtomicM;
    logic [4:0]  AtomicOpM;
    logic        AmoWordM;
    logic        FlushM;
    logic [55:0] PAdrM;
    logic [63:0] WriteDataM;
    logic        BusReq;
    logic        BusWrite;
    logic [55:0] BusAdr;
    logic [7:0]  BusByteEn;
    logic [63:0] BusWData;
    logic        BusAck;
    logic [63:0] BusRData;
    logic        AmoStallM;
    logic        AmoDoneM;
    logic [63:0] ReadDataM;

    int unsigned passCnt = 0;
    int unsigned totalCnt = 0;

    logic [63:0] rWData;
    logic [7:0]  rBe;
    logic [55:0] rAdr;
    logic [63:0] rRData;
    int unsigned rDoneCyc;
    logic        rOk;

    typedef struct {
        logic [4:0]  op;
        logic        word;
        logic [55:0] adr;
        logic [63:0] rs2;
        logic [63:0] mem;
        logic [63:0] expW;
        logic [63:0] expR;
        logic [7:0]  expBe;
    } vecT;

    amo_rmw_seq #(.XLEN(64), .PA_BITS(56)) dut (
        .clk        (clk),
        .reset      (reset),
        .LSURWM     (LSURWM),
        .LSUAtomicM (LSUAtomicM),
        .AtomicOpM  (AtomicOpM),
        .AmoWordM   (AmoWordM),
        .FlushM     (FlushM),
        .PAdrM      (PAdrM),
        .WriteDataM (WriteDataM),
        .BusReq     (BusReq),
        .BusWrite   (BusWrite),
        .BusAdr     (BusAdr),
        .BusByteEn  (BusByteEn),
        .BusWData   (BusWData),
        .BusAck     (BusAck),
        .BusRData   (BusRData),
        .AmoStallM  (AmoStallM),
        .AmoDoneM   (AmoDoneM),
        .ReadDataM  (ReadDataM)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic clearInputs();
        LSURWM     = 2'b00;
        LSUAtomicM = 2'b00;
        AtomicOpM  = 5'b0;
        AmoWordM   = 1'b0;
        PAdrM      = '0;
        WriteDataM = '0;
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic runAmo(input logic [4:0] op, input logic word, input logic [55:0] adr,
                          input logic [63:0] rs2, input logic [63:0] mem,
                          input int unsigned dly, input logic flushW);
        int unsigned cyc;
        logic [55:0] a0;
        logic [63:0] w0;
        logic [7:0]  b0;
        rOk        = 1'b1;
        LSURWM     = 2'b11;
        LSUAtomicM = 2'b10;
        AtomicOpM  = op;
        AmoWordM   = word;
        PAdrM      = adr;
        WriteDataM = rs2;
        FlushM     = 1'b0;
        #1;
        if (AmoStallM !== 1'b1 || BusReq !== 1'b0) rOk = 1'b0;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        clearInputs();
        for (int unsigned t = 0; t < 2; t++) begin
            if (BusReq !== 1'b1 || BusWrite !== (t == 1) || AmoStallM !== 1'b1 || AmoDoneM !== 1'b0)
                rOk = 1'b0;
            a0 = BusAdr;
            w0 = BusWData;
            b0 = BusByteEn;
            if (t == 1 && flushW) FlushM = 1'b1;
            for (int unsigned k = 0; k < dly; k++) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (BusAdr !== a0 || BusWData !== w0 || BusByteEn !== b0 || BusReq !== 1'b1 ||
                    BusWrite !== (t == 1) || AmoStallM !== 1'b1)
                    rOk = 1'b0;
            end
            if (t == 0) begin
                rAdr     = BusAdr;
                BusRData = mem;
            end else begin
                rWData = BusWData;
                rBe    = BusByteEn;
            end
            BusAck = 1'b1;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            BusAck   = 1'b0;
            BusRData = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        rDoneCyc = AmoDoneM ? cyc : 0;
        rRData   = ReadDataM;
        if (AmoStallM !== 1'b0 || BusReq !== 1'b0) rOk = 1'b0;
        FlushM = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        clearInputs();
        FlushM   = 1'b0;
        BusAck   = 1'b0;
        BusRData = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (2) @(negedge clk);
        totalCnt++; if (BusReq !== 1'b0) $display("FAIL reset_busreq: got %b want 0", BusReq); else passCnt++;
        totalCnt++; if (BusWrite !== 1'b0) $display("FAIL reset_buswrite: got %b want 0", BusWrite); else passCnt++;
        totalCnt++; if (AmoStallM !== 1'b0) $display("FAIL reset_stall: got %b want 0", AmoStallM); else passCnt++;
        totalCnt++; if (AmoDoneM !== 1'b0) $display("FAIL reset_done: got %b want 0", AmoDoneM); else passCnt++;
        totalCnt++; if (ReadDataM !== 64'h0) $display("FAIL reset_rdata: got %h want 0", ReadDataM); else passCnt++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_amoadd_d();
        runAmo(5'b00000, 1'b0, 56'h1000, 64'h3, 64'h5, 0, 1'b0);
        totalCnt++; if (rWData !== 64'h8) $display("FAIL add_d_wdata: got %h want %h", rWData, 64'h8); else passCnt++;
        totalCnt++; if (rBe !== 8'hFF) $display("FAIL add_d_byteen: got %h want ff", rBe); else passCnt++;
        totalCnt++; if (rDoneCyc !== 3) $display("FAIL add_d_latency: got %0d want 3", rDoneCyc); else passCnt++;
        totalCnt++; if (rRData !== 64'h5) $display("FAIL add_d_rdata: got %h want 5", rRData); else passCnt++;
        totalCnt++; if (rAdr !== 56'h1000) $display("FAIL add_d_adr: got %h want 1000", rAdr); else passCnt++;
        totalCnt++; if (rOk !== 1'b1) $display("FAIL add_d_handshake: got %b want 1", rOk); else passCnt++;
        @(posedge clk); @(negedge clk);
        totalCnt++; if (AmoDoneM !== 1'b0) $display("FAIL add_d_done_pulse: got %b want 0", AmoDoneM); else passCnt++;
        totalCnt++; if (ReadDataM !== 64'h5) $display("FAIL add_d_rdata_hold: got %h want 5", ReadDataM); else passCnt++;
    endtask

    task automatic test_amomin_w();
        runAmo(5'b10000, 1'b1, 56'h2004, 64'h1, 64'h8000_0000_0000_0001, 0, 1'b0);
        totalCnt++; if (rWData !== 64'h8000_0000_8000_0000) $display("FAIL min_w_wdata: got %h want 8000000080000000", rWData); else passCnt++;
        totalCnt++; if (rBe !== 8'hF0) $display("FAIL min_w_byteen: got %h want f0", rBe); else passCnt++;
        totalCnt++; if (rRData !== 64'hFFFF_FFFF_8000_0000) $display("FAIL min_w_rdata: got %h want ffffffff80000000", rRData); else passCnt++;
        totalCnt++; if (rAdr !== 56'h2000) $display("FAIL min_w_adr: got %h want 2000", rAdr); else passCnt++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_alu_table();
        vecT v[10];
        v[0] = '{5'b00001, 1'b0, 56'h100, 64'hABCD, 64'h1111, 64'hABCD, 64'h1111, 8'hFF};
        v[1] = '{5'b01100, 1'b0, 56'h108, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFF00_FF00_FF00_FF00,
                 64'h0F00_0F00_0F00_0F00, 64'hFF00_FF00_FF00_FF00, 8'hFF};
        v[2] = '{5'b01000, 1'b1, 56'h110, 64'h0F, 64'hAAAA_AAAA_0000_00F0,
                 64'h0000_00FF_0000_00FF, 64'hF0, 8'h0F};
        v[3] = '{5'b00100, 1'b0, 56'h118, 64'h0F, 64'hFF, 64'hF0, 64'hFF, 8'hFF};
        v[4] = '{5'b10100, 1'b0, 56'h120, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF};
        v[5] = '{5'b11000, 1'b1, 56'h128, 64'h1, 64'h0000_0000_FFFF_FFFF,
                 64'h0000_0001_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F};
        v[6] = '{5'b00000, 1'b1, 56'h134, 64'h2, 64'hFFFF_FFFF_0000_0000,
                 64'h0000_0001_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0};
        v[7] = '{5'b11111, 1'b0, 56'h138, 64'h1234, 64'h5678, 64'h1234, 64'h5678, 8'hFF};
        v[8] = '{5'b11100, 1'b1, 56'h144, 64'h7FFF_FFFF, 64'h8000_0000_0000_0000,
                 64'h8000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 8'hF0};
        v[9] = '{5'b10000, 1'b0, 56'h148, 64'h1, 64'h8000_0000_0000_0000,
                 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 8'hFF};
        for (int unsigned i = 0; i < 10; i++) begin
            runAmo(v[i].op, v[i].word, v[i].adr, v[i].rs2, v[i].mem, 0, 1'b0);
            totalCnt++; if (rWData !== v[i].expW) $display("FAIL alu%0d_wdata: got %h want %h", i, rWData, v[i].expW); else passCnt++;
            totalCnt++; if (rRData !== v[i].expR) $display("FAIL alu%0d_rdata: got %h want %h", i, rRData, v[i].expR); else passCnt++;
            totalCnt++; if (rBe !== v[i].expBe) $display("FAIL alu%0d_byteen: got %h want %h", i, rBe, v[i].expBe); else passCnt++;
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_amomaxu_d_wait();
        runAmo(5'b11100, 1'b0, 56'h3008, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3, 1'b0);
        totalCnt++; if (rWData !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL maxu_d_wdata: got %h want ffffffffffffffff", rWData); else passCnt++;
        totalCnt++; if (rBe !== 8'hFF) $display("FAIL maxu_d_byteen: got %h want ff", rBe); else passCnt++;
        totalCnt++; if (rDoneCyc !== 9) $display("FAIL maxu_d_latency: got %0d want 9", rDoneCyc); else passCnt++;
        totalCnt++; if (rOk !== 1'b1) $display("FAIL maxu_d_stable: got %b want 1", rOk); else passCnt++;
        totalCnt++; if (rRData !== 64'h1) $display("FAIL maxu_d_rdata: got %h want 1", rRData); else passCnt++;
        totalCnt++; if (rAdr !== 56'h3008) $display("FAIL maxu_d_adr: got %h want 3008", rAdr); else passCnt++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_flush_idle();
        LSURWM     = 2'b11;
        LSUAtomicM = 2'b10;
        AtomicOpM  = 5'b00000;
        PAdrM      = 56'h500;
        WriteDataM = 64'h1;
        FlushM     = 1'b1;
        #1;
        totalCnt++; if (AmoStallM !== 1'b0) $display("FAIL flush_idle_stall: got %b want 0", AmoStallM); else passCnt++;
        @(posedge clk); @(negedge clk);
        totalCnt++; if (BusReq !== 1'b0) $display("FAIL flush_idle_busreq: got %b want 0", BusReq); else passCnt++;
        clearInputs();
        FlushM = 1'b0;
        @(posedge clk); @(negedge clk);
        totalCnt++; if (BusReq !== 1'b0) $display("FAIL flush_idle_after: got %b want 0", BusReq); else passCnt++;
    endtask

    task automatic test_flush_write();
        runAmo(5'b00000, 1'b0, 56'h4000, 64'h1, 64'h2, 1, 1'b1);
        totalCnt++; if (rWData !== 64'h3) $display("FAIL flush_wr_wdata: got %h want 3", rWData); else passCnt++;
        totalCnt++; if (rDoneCyc !== 5) $display("FAIL flush_wr_done: got %0d want 5", rDoneCyc); else passCnt++;
        totalCnt++; if (rOk !== 1'b1) $display("FAIL flush_wr_handshake: got %b want 1", rOk); else passCnt++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        LSURWM     = 2'b11;
        LSUAtomicM = 2'b10;
        AtomicOpM  = 5'b00000;
        AmoWordM   = 1'b0;
        PAdrM      = 56'h600;
        WriteDataM = 64'h7;
        @(posedge clk); @(negedge clk);
        clearInputs();
        totalCnt++; if (BusReq !== 1'b1) $display("FAIL rst_read_busreq_pre: got %b want 1", BusReq); else passCnt++;
        #2 reset = 1'b1;
        #1;
        totalCnt++; if (BusReq !== 1'b0) $display("FAIL rst_read_busreq: got %b want 0", BusReq); else passCnt++;
        totalCnt++; if (AmoStallM !== 1'b0) $display("FAIL rst_read_stall: got %b want 0", AmoStallM); else passCnt++;
        totalCnt++; if (ReadDataM !== 64'h0) $display("FAIL rst_read_rdata: got %h want 0", ReadDataM); else passCnt++;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        runAmo(5'b00000, 1'b0, 56'h1000, 64'h3, 64'h5, 0, 1'b0);
        totalCnt++; if (rWData !== 64'h8) $display("FAIL rst_next_wdata: got %h want 8", rWData); else passCnt++;
        totalCnt++; if (rRData !== 64'h5) $display("FAIL rst_next_rdata: got %h want 5", rRData); else passCnt++;
        totalCnt++; if (rDoneCyc !== 3) $display("FAIL rst_next_latency: got %0d want 3", rDoneCyc); else passCnt++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_non_amo();
        logic [1:0] atom [4];
        logic [1:0] rwm  [4];
        atom = '{2'b01, 2'b00, 2'b01, 2'b00};
        rwm  = '{2'b00, 2'b01, 2'b10, 2'b11};
        for (int unsigned i = 0; i < 4; i++) begin
            LSUAtomicM = atom[i];
            LSURWM     = rwm[i];
            AtomicOpM  = 5'b00001;
            PAdrM      = 56'h700;
            #1;
            totalCnt++; if (AmoStallM !== 1'b0) $display("FAIL nonamo%0d_stall: got %b want 0", i, AmoStallM); else passCnt++;
            @(posedge clk); @(negedge clk);
            totalCnt++; if (BusReq !== 1'b0) $display("FAIL nonamo%0d_busreq: got %b want 0", i, BusReq); else passCnt++;
        end
        clearInputs();
    endtask

    task automatic test_back_to_back();
        runAmo(5'b00000, 1'b0, 56'h800, 64'h1, 64'hA, 0, 1'b0);
        totalCnt++; if (rWData !== 64'hB) $display("FAIL b2b_first_wdata: got %h want b", rWData); else passCnt++;
        LSURWM     = 2'b11;
        LSUAtomicM = 2'b10;
        AtomicOpM  = 5'b00100;
        AmoWordM   = 1'b0;
        PAdrM      = 56'h808;
        WriteDataM = 64'hFF;
        #1;
        totalCnt++; if (AmoDoneM !== 1'b1) $display("FAIL b2b_done: got %b want 1", AmoDoneM); else passCnt++;
        totalCnt++; if (AmoStallM !== 1'b0) $display("FAIL b2b_no_start_in_done: got %b want 0", AmoStallM); else passCnt++;
        @(posedge clk); @(negedge clk);
        runAmo(5'b00100, 1'b0, 56'h808, 64'hFF, 64'h0F, 0, 1'b0);
        totalCnt++; if (rOk !== 1'b1) $display("FAIL b2b_second_handshake: got %b want 1", rOk); else passCnt++;
        totalCnt++; if (rWData !== 64'hF0) $display("FAIL b2b_second_wdata: got %h want f0", rWData); else passCnt++;
        totalCnt++; if (rRData !== 64'h0F) $display("FAIL b2b_second_rdata: got %h want f", rRData); else passCnt++;
        totalCnt++; if (rDoneCyc !== 3) $display("FAIL b2b_second_latency: got %0d want 3", rDoneCyc); else passCnt++;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_amoadd_d();
        test_amomin_w();
        test_alu_table();
        test_amomaxu_d_wait();
        test_flush_idle();
        test_flush_write();
        test_reset_mid_read();
        test_non_amo();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
